bids22_cfg_master: RTL and testbench

- Initiator for the bids22 control port (C_op, C_data, C_start, ready, err).
- Takes one configuration request per handshake and plays it into the bid FSM as an ordered opcode sequence: UNLOCK, LOADX, LOADY, LOADZ, SETMASK, SETTIMER, SETBIDCHARGE, LOCK.
- Waits on ready between steps and reports completion or the first error.
- Sits between a testbench or host bus and the bids22 FSM, in place of hand-driven C_* stimulus.

---
 rtl/bids22defs.sv | 88 ++++++++
 rtl/bids22_step_sel.sv | 25 ++
 rtl/bids22_cfg_master.sv | 195 +++++++++++++++++++
 tb/tb_bids22_cfg_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bids22defs.sv
`default_nettype none
// ============================================================================
//  Package     : bids22defs
//  Description : Shared bids22 control-port types and configuration-step helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package bids22defs;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8
    } opcodes_t;

    typedef enum logic [2:0] {
        NOERROR          = 3'd0,
        BADKEY           = 3'd1,
        ALREADY_UNLOCKED = 3'd2,
        CANNOT_LOCK      = 3'd3,
        INVALID_OP       = 3'd4
    } outerrors_t;

    // Widest configuration field carried in a captured request.
    localparam int CFG_DW = 32;

    typedef enum logic [2:0] {
        STEP_UNLOCK = 3'd0,
        STEP_X      = 3'd1,
        STEP_Y      = 3'd2,
        STEP_Z      = 3'd3,
        STEP_MASK   = 3'd4,
        STEP_TIMER  = 3'd5,
        STEP_CHARGE = 3'd6,
        STEP_LOCK   = 3'd7
    } cfg_step_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CLEANUP = 3'd3,
        S_DONE    = 3'd4
    } cfg_state_t;

    typedef struct packed {
        logic [CFG_DW-1:0] key;
        logic [CFG_DW-1:0] x;
        logic [CFG_DW-1:0] y;
        logic [CFG_DW-1:0] z;
        logic [CFG_DW-1:0] mask;
        logic [CFG_DW-1:0] timer;
        logic [CFG_DW-1:0] charge;
        logic [5:0]        en;
    } cfg_req_t;

    function automatic opcodes_t step_op(input cfg_step_t s);
        case (s)
            STEP_UNLOCK: step_op = UNLOCK;
            STEP_X:      step_op = LOADX;
            STEP_Y:      step_op = LOADY;
            STEP_Z:      step_op = LOADZ;
            STEP_MASK:   step_op = SETMASK;
            STEP_TIMER:  step_op = SETTIMER;
            STEP_CHARGE: step_op = SETBIDCHARGE;
            default:     step_op = LOCK;
        endcase
    endfunction

    function automatic logic [CFG_DW-1:0] step_data(input cfg_step_t s, input cfg_req_t r);
        case (s)
            STEP_X:      step_data = r.x;
            STEP_Y:      step_data = r.y;
            STEP_Z:      step_data = r.z;
            STEP_MASK:   step_data = r.mask;
            STEP_TIMER:  step_data = r.timer;
            STEP_CHARGE: step_data = r.charge;
            default:     step_data = r.key;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bids22_step_sel.sv
`default_nettype none
// ============================================================================
//  Module      : bids22_step_sel
//  Description : Picks the next enabled configuration step after cur_step.
//  Revision    : 1.0 - initial release
// ============================================================================
module bids22_step_sel
    import bids22defs::*;
(
    input  logic [2:0] cur_step,
    input  logic [5:0] cfg_en,
    output logic [2:0] next_step
);

    // Scan high to low so the lowest enabled step above cur_step wins; LOCK if none.
    always_comb begin
        next_step = 3'(STEP_LOCK);
        for (int i = 6; i >= 1; i--) begin
            if (cfg_en[i-1] && (3'(i) > cur_step))
                next_step = 3'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bids22_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module      : bids22_cfg_master
//  Description : Plays one configuration request into the bids22 FSM as an
//                UNLOCK..LOCK opcode sequence and reports the outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module bids22_cfg_master
    import bids22defs::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DATAWIDTH-1:0] cfg_key,
    input  logic [DATAWIDTH-1:0] cfg_x,
    input  logic [DATAWIDTH-1:0] cfg_y,
    input  logic [DATAWIDTH-1:0] cfg_z,
    input  logic [DATAWIDTH-1:0] cfg_mask,
    input  logic [DATAWIDTH-1:0] cfg_timer,
    input  logic [DATAWIDTH-1:0] cfg_charge,
    input  logic [5:0]           cfg_en,
    output logic [3:0]           C_op,
    output logic [DATAWIDTH-1:0] C_data,
    output logic                 C_start,
    input  logic                 ready,
    input  logic [2:0]           err,
    output logic                 done,
    output logic [2:0]           status,
    output logic [3:0]           fail_op,
    output logic                 timed_out
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    cfg_state_t            r_state;
    cfg_req_t              r_req;
    cfg_step_t             r_step;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_cfg_ready;
    opcodes_t              r_c_op;
    logic [DATAWIDTH-1:0]  r_c_data;
    logic                  r_c_start;
    logic                  r_done;
    outerrors_t            r_status;
    opcodes_t              r_fail_op;
    logic                  r_timed_out;

    logic [2:0]            w_next_step;
    cfg_step_t             w_issue_step;
    opcodes_t              w_issue_op;
    logic [DATAWIDTH-1:0]  w_issue_data;
    logic                  w_err_hit;
    logic                  w_ready_ok;
    logic                  w_tmo;

    bids22_step_sel u_step_sel (
        .cur_step  (r_step),
        .cfg_en    (r_req.en),
        .next_step (w_next_step)
    );

    assign w_err_hit  = (err != NOERROR);
    // r_cnt is zero in the cycle C_start is visible, so ready there is stale.
    assign w_ready_ok = ready && (r_cnt != '0);
    assign w_tmo      = (r_cnt == c_TMO_LAST);

    always_comb begin
        w_issue_step = cfg_step_t'(w_next_step);
        if (r_state == S_ISSUE)
            w_issue_step = STEP_UNLOCK;
        else if (w_err_hit)
            w_issue_step = STEP_LOCK;
    end

    assign w_issue_op   = step_op(w_issue_step);
    assign w_issue_data = DATAWIDTH'(step_data(w_issue_step, r_req));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req       <= '0;
            r_step      <= STEP_UNLOCK;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b1;
            r_c_op      <= NO_OP;
            r_c_data    <= '0;
            r_c_start   <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= NOERROR;
            r_fail_op   <= NO_OP;
            r_timed_out <= 1'b0;
        end else begin
            r_c_start <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_req <= '{key: CFG_DW'(cfg_key), x: CFG_DW'(cfg_x), y: CFG_DW'(cfg_y),
                                   z: CFG_DW'(cfg_z), mask: CFG_DW'(cfg_mask),
                                   timer: CFG_DW'(cfg_timer), charge: CFG_DW'(cfg_charge),
                                   en: cfg_en};
                        r_status    <= NOERROR;
                        r_fail_op   <= NO_OP;
                        r_timed_out <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ready) begin
                        r_c_start <= 1'b1;
                        r_c_op    <= w_issue_op;
                        r_c_data  <= w_issue_data;
                        r_step    <= w_issue_step;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end else if (w_tmo) begin
                        r_timed_out <= 1'b1;
                        r_status    <= INVALID_OP;
                        r_fail_op   <= NO_OP;
                        r_done      <= 1'b1;
                        r_cfg_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (w_ready_ok) begin
                        if (w_err_hit) begin
                            r_status  <= outerrors_t'(err);
                            r_fail_op <= r_c_op;
                        end
                        if ((w_err_hit && r_step == STEP_UNLOCK) || (!w_err_hit && r_step == STEP_LOCK)) begin
                            r_done      <= 1'b1;
                            r_cfg_ready <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            // Next step (or cleanup LOCK) issues straight from this cycle.
                            r_c_start <= 1'b1;
                            r_c_op    <= w_issue_op;
                            r_c_data  <= w_issue_data;
                            r_step    <= w_issue_step;
                            r_cnt     <= '0;
                            r_state   <= w_err_hit ? S_CLEANUP : S_WAIT;
                        end
                    end else if (w_tmo) begin
                        r_timed_out <= 1'b1;
                        r_status    <= INVALID_OP;
                        r_fail_op   <= r_c_op;
                        r_done      <= 1'b1;
                        r_cfg_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_CLEANUP: begin
                    // The cleanup LOCK result never overrides the recorded first failure.
                    if (w_ready_ok || w_tmo) begin
                        r_timed_out <= !w_ready_ok;
                        r_done      <= 1'b1;
                        r_cfg_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign C_op      = r_c_op;
    assign C_data    = r_c_data;
    assign C_start   = r_c_start;
    assign done      = r_done;
    assign status    = r_status;
    assign fail_op   = r_fail_op;
    assign timed_out = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_bids22_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bids22_cfg_master
//  Description : Scoreboard bench for bids22_cfg_master against a simple FSM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bids22_cfg_master;
    import bids22defs::*;

    localparam logic [31:0] c_KEY    = 32'h0000_A5A5;
    localparam logic [31:0] c_X      = 32'h1111_0001;
    localparam logic [31:0] c_Y      = 32'h2222_0002;
    localparam logic [31:0] c_Z      = 32'h3333_0003;
    localparam logic [31:0] c_MASK   = 32'h0000_00FF;
    localparam logic [31:0] c_TIMER  = 32'h0000_0040;
    localparam logic [31:0] c_CHARGE = 32'h0000_0007;

    typedef struct { logic [3:0] op; logic [31:0] data; } iss_t;
    typedef struct { logic [2:0] st; logic [3:0] fop; logic tmo; int cyc; } done_t;

    logic        clk, reset, cfg_valid, cfg_ready, C_start, ready, done, timed_out;
    logic [31:0] cfg_key, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_charge, C_data;
    logic [5:0]  cfg_en;
    logic [3:0]  C_op, fail_op, hold_op, fault_op;
    logic [2:0]  err, status, fault_err;
    logic        r_held, prev_start;
    logic [2:0]  r_err;

    iss_t  exp_iss[$];
    done_t exp_done[$];
    int    cyc, checks, errors;

    bids22_cfg_master #(.DATAWIDTH(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_key(cfg_key), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_charge(cfg_charge),
        .cfg_en(cfg_en), .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .ready(ready), .err(err), .done(done), .status(status),
        .fail_op(fail_op), .timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FSM model: busy during the start cycle, optionally stalls on hold_op, errors on fault_op.
    initial begin r_held = 1'b0; r_err = NOERROR; end
    always @(posedge clk) begin
        if (C_start && C_op == hold_op) r_held <= 1'b1;
        else if (hold_op == 4'd0)       r_held <= 1'b0;
        if (C_start) r_err <= (C_op == fault_op) ? fault_err : NOERROR;
    end
    assign ready = ~r_held & ~C_start;
    assign err   = r_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (C_start) begin
                chk("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
                if (exp_iss.size() == 0) begin
                    chk("unexpected_start_op", {28'd0, C_op}, 32'd0);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("C_op", {28'd0, C_op}, {28'd0, e.op});
                    chk("C_data", C_data, e.data);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("status", {29'd0, status}, {29'd0, d.st});
                    chk("fail_op", {28'd0, fail_op}, {28'd0, d.fop});
                    chk("timed_out", {31'd0, timed_out}, {31'd0, d.tmo});
                    chk("done_cycle", cyc, d.cyc);
                    chk("cfg_ready_in_done", {31'd0, cfg_ready}, 32'd1);
                    chk("issues_all_seen", exp_iss.size(), 32'd0);
                end
            end
        end
        prev_start = C_start;
    end

    task automatic push_iss(input logic [3:0] op, input logic [31:0] data);
        iss_t e;
        e.op = op; e.data = data;
        exp_iss.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] st, input logic [3:0] fop, input logic tmo, input int at);
        done_t d;
        d.st = st; d.fop = fop; d.tmo = tmo; d.cyc = at;
        exp_done.push_back(d);
    endtask

    // Returns the cycle number of the accepting cycle; fields are scrambled after accept.
    task automatic send(input logic [5:0] en, output int acc);
        int n = 0;
        while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("cfg_ready_timeout", 32'd0, 32'd1);
        cfg_key = c_KEY; cfg_x = c_X; cfg_y = c_Y; cfg_z = c_Z;
        cfg_mask = c_MASK; cfg_timer = c_TIMER; cfg_charge = c_CHARGE;
        cfg_en = en; cfg_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_key = 32'hDEAD_BEEF; cfg_x = 32'hDEAD_BEEF; cfg_y = 32'hDEAD_BEEF; cfg_z = 32'hDEAD_BEEF;
        cfg_mask = 32'hDEAD_BEEF; cfg_timer = 32'hDEAD_BEEF; cfg_charge = 32'hDEAD_BEEF; cfg_en = 6'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_done.size() != 0 || exp_iss.size() != 0) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("scoreboard_drain_timeout", exp_done.size() + exp_iss.size(), 32'd0);
        exp_iss.delete(); exp_done.delete();
        hold_op = 4'd0; fault_op = 4'd0; fault_err = NOERROR;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_full();
        push_iss(4'd1, c_KEY);  push_iss(4'd3, c_X);     push_iss(4'd4, c_Y);
        push_iss(4'd5, c_Z);    push_iss(4'd6, c_MASK);  push_iss(4'd7, c_TIMER);
        push_iss(4'd8, c_CHARGE); push_iss(4'd2, c_KEY);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
        chk({tag, "_C_op"}, {28'd0, C_op}, 32'd0);
        chk({tag, "_C_data"}, C_data, 32'd0);
        chk({tag, "_C_start"}, {31'd0, C_start}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_status"}, {29'd0, status}, {29'd0, NOERROR});
        chk({tag, "_fail_op"}, {28'd0, fail_op}, 32'd0);
        chk({tag, "_timed_out"}, {31'd0, timed_out}, 32'd0);
    endtask

    initial begin
        int acc;
        checks = 0; errors = 0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_en = 6'd0;
        cfg_key = '0; cfg_x = '0; cfg_y = '0; cfg_z = '0; cfg_mask = '0; cfg_timer = '0; cfg_charge = '0;
        hold_op = 4'd0; fault_op = 4'd0; fault_err = NOERROR;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All steps, clean run: done 18 cycles after accept.
        push_full();
        send(6'h3F, acc);
        push_done(NOERROR, 4'd0, 1'b0, acc + 18);
        wait_idle();

        // X and TIMER only.
        push_iss(4'd1, c_KEY); push_iss(4'd3, c_X); push_iss(4'd7, c_TIMER); push_iss(4'd2, c_KEY);
        send(6'b010001, acc);
        push_done(NOERROR, 4'd0, 1'b0, acc + 10);
        wait_idle();

        // BADKEY on UNLOCK: no LOCK cleanup.
        fault_op = 4'd1; fault_err = BADKEY;
        push_iss(4'd1, c_KEY);
        send(6'h3F, acc);
        push_done(BADKEY, 4'd1, 1'b0, acc + 4);
        wait_idle();

        // INVALID_OP on LOADZ: cleanup LOCK follows.
        fault_op = 4'd5; fault_err = INVALID_OP;
        push_iss(4'd1, c_KEY); push_iss(4'd3, c_X); push_iss(4'd4, c_Y); push_iss(4'd5, c_Z);
        push_iss(4'd2, c_KEY);
        send(6'h3F, acc);
        push_done(INVALID_OP, 4'd5, 1'b0, acc + 12);
        wait_idle();

        // FSM stalls after SETMASK (issued at cycle 10): timeout 64 cycles later.
        hold_op = 4'd6;
        push_iss(4'd1, c_KEY); push_iss(4'd3, c_X); push_iss(4'd4, c_Y); push_iss(4'd5, c_Z);
        push_iss(4'd6, c_MASK);
        send(6'h3F, acc);
        push_done(INVALID_OP, 4'd6, 1'b1, acc + 74);
        wait_idle();

        // Reset while waiting on LOADY.
        hold_op = 4'd4;
        push_iss(4'd1, c_KEY); push_iss(4'd3, c_X); push_iss(4'd4, c_Y);
        send(6'h3F, acc);
        repeat (7) @(negedge clk);
        chk("pre_reset_all_issued", exp_iss.size(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        reset = 1'b0;
        wait_idle();

        // Clean run after the mid-sequence reset.
        push_full();
        send(6'h3F, acc);
        push_done(NOERROR, 4'd0, 1'b0, acc + 18);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
